// File: rtl/fifo_drain_arbiter_pkg.sv
// Shared helpers for the fifo drain arbiter: index width derivation.
package fifo_arb_pkg;

  // Width of a queue index; a single queue still gets a 1-bit index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_drain_arbiter_if.sv
// Bundle of queue-side and consumer-side signals around the drain arbiter.
// master = the arbiter, slave = the surrounding fifos + consumer.
interface fifo_drain_arbiter_if #(
  parameter int N_QUEUES = 4,
  parameter int DWIDTH   = 16
);
  localparam int IDX_W = fifo_arb_pkg::idx_w(N_QUEUES);

  logic                         enable;
  logic [N_QUEUES-1:0]          q_empty;
  logic [N_QUEUES-1:0]          q_full;
  logic [N_QUEUES*DWIDTH-1:0]   q_dout;
  logic [N_QUEUES-1:0]          q_rd_en;
  logic [DWIDTH-1:0]            out_data;
  logic [IDX_W-1:0]             out_src;
  logic                         out_valid;
  logic                         out_ready;
  logic                         idle;

  modport master (
    input  enable, q_empty, q_full, q_dout, out_ready,
    output q_rd_en, out_data, out_src, out_valid, idle
  );

  modport slave (
    output enable, q_empty, q_full, q_dout, out_ready,
    input  q_rd_en, out_data, out_src, out_valid, idle
  );

endinterface

// File: rtl/fifo_drain_arbiter_rr_picker.sv
// Rotating find-first: lowest set bit of vec at or after ptr, wrapping mod N.
module rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     vec,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [N-1:0]   rot;
  logic [IDX_W:0] sum;

  // Rotate so bit 0 is the queue at ptr, then scan down so the nearest hit wins.
  always_comb begin
    rot   = N'({vec, vec} >> ptr);
    found = |vec;
    idx   = '0;
    sum   = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) begin
        sum = {1'b0, ptr} + (IDX_W+1)'(j);
        // Explicit wrap: N need not be a power of two.
        if (sum >= (IDX_W+1)'(N)) sum = sum - (IDX_W+1)'(N);
        idx = sum[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_drain_arbiter.sv
// Drains N_QUEUES fwft fifos into one registered valid/ready output stage.
// Full queues are served first; ties are broken round-robin from rr_ptr.
module fifo_drain_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_QUEUES = 4,
  parameter int DWIDTH   = 16
) (
  input logic                  clk,
  input logic                  rst,
  fifo_drain_arbiter_if.master bus
);

  localparam int IDX_W = idx_w(N_QUEUES);

  logic [N_QUEUES-1:0] req, urg, rd_en;
  logic                urg_found, req_found, load;
  logic [IDX_W-1:0]    urg_idx, req_idx, gnt;
  logic [DWIDTH-1:0]   gnt_data;

  logic                out_valid_q, out_valid_d;
  logic [DWIDTH-1:0]   out_data_q,  out_data_d;
  logic [IDX_W-1:0]    out_src_q,   out_src_d;
  logic [IDX_W-1:0]    rr_ptr_q,    rr_ptr_d;

  // Reset gates requests so no queue is popped while rst is low.
  assign req  = rst ? (~bus.q_empty & {N_QUEUES{bus.enable}}) : '0;
  assign urg  = req & bus.q_full;
  assign load = (|req) & (~out_valid_q | bus.out_ready);

  rr_picker #(.N(N_QUEUES), .IDX_W(IDX_W)) u_pick_urg (
    .vec(urg), .ptr(rr_ptr_q), .found(urg_found), .idx(urg_idx)
  );

  rr_picker #(.N(N_QUEUES), .IDX_W(IDX_W)) u_pick_req (
    .vec(req), .ptr(rr_ptr_q), .found(req_found), .idx(req_idx)
  );

  // req_found is implied by load; only the urgent result needs to steer.
  assign gnt = urg_found ? urg_idx : req_idx;

  // One-hot pop decode and head-word mux for the granted queue.
  always_comb begin
    rd_en    = '0;
    gnt_data = '0;
    for (int i = 0; i < N_QUEUES; i++) begin
      if (gnt == IDX_W'(i)) begin
        rd_en[i] = load & req_found;
        gnt_data = bus.q_dout[i*DWIDTH +: DWIDTH];
      end
    end
  end

  // Output stage: capture on load (also covers accept+load with no bubble),
  // otherwise drop valid once the consumer takes the word.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = gnt_data;
      out_src_d   = gnt;
      rr_ptr_d    = (gnt == IDX_W'(N_QUEUES - 1)) ? '0 : gnt + IDX_W'(1);
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State register; reset discards the held word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.q_rd_en   = rd_en;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.idle      = ~out_valid_q & (&bus.q_empty);

endmodule
